// File: rtl/clk_div_multi_pkg.sv
// Shared constants for the multi-channel clock-enable generator.
// Reset half-periods assume a 20 MHz system clock.
package clk_div_multi_pkg;

  localparam int CNT_W_DEF = 25;

  localparam int HP_20KHZ = 500;
  localparam int HP_1KHZ  = 10000;
  localparam int HP_60HZ  = 166667;
  localparam int HP_1HZ   = 10000000;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_multi_chan.sv
// One divider channel: half-period counter, tick strobe, 50 % clk_out
// and a single-entry pending half-period applied at terminal count.
module clk_div_multi_chan
  import clk_div_multi_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] HP_INIT = CNT_W'(HP_20KHZ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             ld_now,
  input  logic             ld_def,
  input  logic [CNT_W-1:0] ld_hp,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] pend_hp_q, pend_hp_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             terminal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      hp_q      <= HP_INIT;
      pend_hp_q <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      pend_hp_q <= pend_hp_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    pend_hp_d = pend_hp_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    pend_d    = pend_q;
    // hp == 0 is excluded here so hp - 1 never wraps into a live compare
    terminal  = (hp_q != '0) && (cnt_q == hp_q - CNT_W'(1));

    if (sync) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      if (pend_q) begin
        hp_d   = pend_hp_q;
        pend_d = 1'b0;
      end
    end else if (hp_q == '0) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      if (pend_q) begin
        hp_d   = pend_hp_q;
        pend_d = 1'b0;
      end
    end else if (en) begin
      if (terminal) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
        if (pend_q) begin
          hp_d   = pend_hp_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Config loads land after sync so an immediate load wins for this channel
    // and a deferred load issued alongside sync is kept pending.
    if (ld_now) begin
      hp_d      = ld_hp;
      cnt_d     = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      pend_d    = 1'b0;
    end
    if (ld_def) begin
      pend_d    = 1'b1;
      pend_hp_d = ld_hp;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign pend    = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable generator: NUM_CH dividers off the 20 MHz clock
// with a valid/ready reprogramming port shared by all channels.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(HP_1HZ), CNT_W'(HP_60HZ),
                                                 CNT_W'(HP_1KHZ), CNT_W'(HP_20KHZ)},
  localparam int                     CH_W     = ch_w(NUM_CH)
) (
  input  logic              clk_20MHz,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_hp,
  input  logic              cfg_now,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] ld_now;
  logic [NUM_CH-1:0] ld_def;
  logic              cfg_in_range;
  logic              cfg_fire;
  logic              cfg_err_q, cfg_err_d;

  always_comb begin
    cfg_in_range = (32'(cfg_ch) < 32'(NUM_CH));
    cfg_ready    = 1'b1;
    ld_now       = '0;
    ld_def       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_in_range && (cfg_ch == CH_W'(i))) begin
        cfg_ready = ~pend[i];
      end
    end
    cfg_fire = cfg_valid & cfg_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_fire && cfg_in_range && (cfg_ch == CH_W'(i))) begin
        ld_now[i] = cfg_now;
        ld_def[i] = ~cfg_now;
      end
    end
    cfg_err_d = cfg_fire & ~cfg_in_range;
  end

  always_ff @(posedge clk_20MHz) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_multi_chan #(
      .CNT_W   (CNT_W),
      .HP_INIT (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk     (clk_20MHz),
      .rst_n   (rst_n),
      .en      (en[i]),
      .sync    (sync),
      .ld_now  (ld_now[i]),
      .ld_def  (ld_def[i]),
      .ld_hp   (cfg_hp),
      .tick    (tick[i]),
      .clk_out (clk_out[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: stimulus queues hand-computed tick/err
// events by cycle number, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_clk_div_multi;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 25;
  localparam int CH_W   = 3;

  logic              clk_20MHz = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NUM_CH-1:0] en        = '0;
  logic              sync      = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch    = '0;
  logic [CNT_W-1:0]  cfg_hp    = '0;
  logic              cfg_now   = 1'b0;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  clk_div_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT ({25'd100, 25'd10000000, 25'd166667, 25'd10000, 25'd500})
  ) dut (
    .clk_20MHz (clk_20MHz),
    .rst_n     (rst_n),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_hp    (cfg_hp),
    .cfg_now   (cfg_now),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  always #25 clk_20MHz = ~clk_20MHz;

  int cyc = 0;
  always @(posedge clk_20MHz) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] tick;
    logic [4:0] clk;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [4:0] tk, input logic [4:0] ck, input logic er);
    exp_t e;
    int   pos;
    e.cyc  = c;
    e.tick = tk;
    e.clk  = ck;
    e.err  = er;
    pos    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  always @(negedge clk_20MHz) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_event: expected tick=%b err=%b at cycle %0d, nothing seen",
               sb[0].tick, sb[0].err, sb[0].cyc);
      sb.delete(0);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check("ev_tick", 32'(tick), 32'(mon_e.tick));
      check("ev_clk_out", 32'(clk_out), 32'(mon_e.clk));
      check("ev_cfg_err", 32'(cfg_err), 32'(mon_e.err));
    end else if (tick != '0 || cfg_err) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_output: tick=%b cfg_err=%b, required none (cycle %0d)",
               tick, cfg_err, cyc);
    end
  end

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk_20MHz);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    if (c > cyc) tick_wait(c - cyc);
  endtask

  task automatic cfg(input logic [CH_W-1:0] ch, input int hp, input logic now);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_hp    = CNT_W'(hp);
    cfg_now   = now;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int r, t, u, v, w, x, n;

  initial begin
    tick_wait(3);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // ch0 at its reset half-period of 500
    r     = cyc;
    rst_n = 1'b1;
    en    = 5'b00001;
    push_ev(r + 500,  5'b00001, 5'b00001, 1'b0);
    push_ev(r + 1000, 5'b00001, 5'b00000, 1'b0);
    push_ev(r + 1500, 5'b00001, 5'b00001, 1'b0);
    goto_cyc(r + 1600);

    // immediate reprogram of ch1 to hp = 3
    t  = cyc;
    en = 5'b00011;
    cfg(3'd1, 3, 1'b1);
    check("ready_ch1_idle", 32'(cfg_ready), 32'd1);
    push_ev(t + 4, 5'b00010, 5'b00011, 1'b0);
    push_ev(t + 7, 5'b00010, 5'b00001, 1'b0);
    tick_wait(1);
    cfg_valid = 1'b0;
    goto_cyc(t + 8);

    // deferred reprogram of ch0 mid-period, then a stalled second request
    u  = cyc;
    en = 5'b00001;
    cfg(3'd0, 10, 1'b0);
    check("ready_ch0_first", 32'(cfg_ready), 32'd1);
    push_ev(r + 2000, 5'b00001, 5'b00000, 1'b0);
    push_ev(r + 2010, 5'b00001, 5'b00001, 1'b0);
    push_ev(r + 2030, 5'b00001, 5'b00000, 1'b0);
    tick_wait(1);
    check("ready_ch0_pending", 32'(cfg_ready), 32'd0);
    cfg(3'd0, 20, 1'b0);
    n = 0;
    while (!cfg_ready && n < 600) begin
      tick_wait(1);
      n++;
    end
    check("stall_release_cycle", 32'(cyc), 32'(r + 2000));
    tick_wait(1);
    cfg_valid = 1'b0;

    // en[0] low for 37 cycles mid-count
    goto_cyc(r + 2035);
    en = 5'b00000;
    push_ev(r + 2087, 5'b00001, 5'b00001, 1'b0);
    push_ev(r + 2107, 5'b00001, 5'b00000, 1'b0);
    goto_cyc(r + 2054);
    check("pause_clk_hold", 32'(clk_out), 32'd0);
    goto_cyc(r + 2072);
    en = 5'b00001;
    goto_cyc(r + 2110);
    en = 5'b00000;

    // ch2 stopped by hp = 0, restarted with hp = 2, stopped again
    goto_cyc(r + 2115);
    v  = cyc;
    en = 5'b00100;
    cfg(3'd2, 0, 1'b1);
    tick_wait(1);
    cfg_valid = 1'b0;
    goto_cyc(v + 5);
    check("stop_clk_zero", 32'(clk_out), 32'd0);
    goto_cyc(v + 10);
    cfg(3'd2, 2, 1'b1);
    push_ev(v + 13, 5'b00100, 5'b00100, 1'b0);
    push_ev(v + 15, 5'b00100, 5'b00000, 1'b0);
    push_ev(v + 17, 5'b00100, 5'b00100, 1'b0);
    tick_wait(1);
    cfg_valid = 1'b0;
    goto_cyc(v + 17);
    cfg(3'd2, 0, 1'b1);
    tick_wait(1);
    cfg_valid = 1'b0;
    tick_wait(1);
    check("restop_clk_cleared", 32'(clk_out), 32'd0);

    // out-of-range channel
    goto_cyc(v + 20);
    w  = cyc;
    en = 5'b00000;
    cfg(3'd5, 9, 1'b1);
    check("ready_out_of_range", 32'(cfg_ready), 32'd1);
    push_ev(w + 1, 5'b00000, 5'b00000, 1'b1);
    tick_wait(1);
    cfg_valid = 1'b0;

    // staggered hp = 4 on ch0..ch3, then sync realigns them
    goto_cyc(w + 5);
    x  = cyc;
    en = 5'b01111;
    push_ev(x + 5,  5'b00001, 5'b00001, 1'b0);
    push_ev(x + 6,  5'b00010, 5'b00011, 1'b0);
    push_ev(x + 7,  5'b00100, 5'b00111, 1'b0);
    push_ev(x + 8,  5'b01000, 5'b01111, 1'b0);
    push_ev(x + 9,  5'b00001, 5'b01110, 1'b0);
    push_ev(x + 10, 5'b00010, 5'b01100, 1'b0);
    push_ev(x + 15, 5'b01111, 5'b01111, 1'b0);
    push_ev(x + 19, 5'b01111, 5'b00000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cfg(CH_W'(c), 4, 1'b1);
      tick_wait(1);
    end
    cfg_valid = 1'b0;
    goto_cyc(x + 10);
    sync = 1'b1;
    tick_wait(1);
    sync = 1'b0;
    tick_wait(1);
    check("sync_clk_cleared", 32'(clk_out), 32'd0);
    goto_cyc(x + 19);
    en = 5'b00000;

    goto_cyc(x + 40);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
